// File: rtl/nes_joypad_pkg.sv
// ---------------------------------------------------------------------------
// nes_joypad_pkg
//
// Shared definitions for the NES standard-controller path. The USB HID
// decoders and the joypad serializer both import these.
//
// Contents:
//   BTN_WIDTH           number of buttons on a standard pad (8)
//   BTN_A .. BTN_RIGHT  bit index of each button within the 8-bit state
//                       {right,left,down,up,start,select,b,a}
//   socd_clean()        opposite-direction cleaning of a button vector
// ---------------------------------------------------------------------------
package nes_joypad_pkg;

    localparam int BTN_WIDTH = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Games misbehave when a pad reports both opposite directions at once.
    // The cleaner neutralises a conflicting pair by dropping both bits. The
    // up/down pair and the left/right pair are judged independently.
    function automatic logic [BTN_WIDTH-1:0] socd_clean(
        input logic [BTN_WIDTH-1:0] btn,
        input logic                 enable
    );
        logic [BTN_WIDTH-1:0] res;
        res = btn;
        if (enable) begin
            if (btn[BTN_UP] && btn[BTN_DOWN]) begin
                res[BTN_UP]   = 1'b0;
                res[BTN_DOWN] = 1'b0;
            end
            if (btn[BTN_LEFT] && btn[BTN_RIGHT]) begin
                res[BTN_LEFT]  = 1'b0;
                res[BTN_RIGHT] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/nes_joypad_port.sv
// ---------------------------------------------------------------------------
// nes_joypad_port
//
// One NES controller port. It models the 4021 shift register inside a
// standard pad. While strobe is high the register keeps reloading from the
// (optionally SOCD-cleaned) buttons. While strobe is low each read pulse
// shifts the register right and feeds a 1 in at the top. That 1-fill
// makes reads past the eighth return 1, as on a real pad, so no counter
// is needed.
//
// Parameters:
//   C_SOCD    1 = clean opposite directions, 0 = pass buttons raw
// Ports:
//   i_clk     core clock, rising edge
//   i_rst_n   asynchronous active-low reset; clears the register
//   i_btn     8-bit button state, active-high
//   i_strobe  latch level; when high the register reloads continuously
//   i_read    one-cycle pulse per CPU read of this port
//   o_data    serial data, the register's bit 0 (registered)
// ---------------------------------------------------------------------------
module nes_joypad_port
    import nes_joypad_pkg::*;
#(
    parameter logic C_SOCD = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BTN_WIDTH-1:0] i_btn,
    input  logic                 i_strobe,
    input  logic                 i_read,
    output logic                 o_data
);

    logic [BTN_WIDTH-1:0] sr_q;
    logic [BTN_WIDTH-1:0] sr_d;

    // Strobe outranks read, so a read that arrives while the CPU is still
    // holding strobe high is lost, as on the real hardware. Nothing special
    // happens when strobe falls. The value loaded on the last strobe-high
    // edge is simply what gets shifted out.
    always_comb begin
        sr_d = sr_q;
        if (i_strobe) begin
            sr_d = socd_clean(i_btn, C_SOCD);
        end else if (i_read) begin
            sr_d = {1'b1, sr_q[BTN_WIDTH-1:1]};
        end
    end

    // Register stage. Reset clears any partial shift. The next strobe
    // starts the sequence again from A.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_data = sr_q[0];

endmodule

// File: rtl/nes_joypad_serializer.sv
// ---------------------------------------------------------------------------
// nes_joypad_serializer
//
// Emulates both NES standard-controller ports behind $4016/$4017. Each
// player's parallel button state is serialized with the strobe/read
// protocol. Both ports share the strobe. Each port has its own read pulse.
//
// Parameters:
//   C_SOCD     1 = clean opposite directions, 0 = pass directions raw
// Ports:
//   i_clk      core clock, rising edge
//   i_rst_n    asynchronous active-low reset (release already synchronized)
//   i_btn1     player 1 buttons {right,left,down,up,start,select,b,a}
//   i_btn2     player 2 buttons, same encoding
//   i_strobe   level of CPU-written $4016 bit0
//   i_read1    one-cycle pulse per CPU read of $4016
//   i_read2    one-cycle pulse per CPU read of $4017
//   o_data1    serial data, port 1 (1 = pressed)
//   o_data2    serial data, port 2 (1 = pressed)
// ---------------------------------------------------------------------------
module nes_joypad_serializer
    import nes_joypad_pkg::*;
#(
    parameter logic C_SOCD = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BTN_WIDTH-1:0] i_btn1,
    input  logic [BTN_WIDTH-1:0] i_btn2,
    input  logic                 i_strobe,
    input  logic                 i_read1,
    input  logic                 i_read2,
    output logic                 o_data1,
    output logic                 o_data2
);

    nes_joypad_port #(
        .C_SOCD (C_SOCD)
    ) u_port1 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_btn    (i_btn1),
        .i_strobe (i_strobe),
        .i_read   (i_read1),
        .o_data   (o_data1)
    );

    nes_joypad_port #(
        .C_SOCD (C_SOCD)
    ) u_port2 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_btn    (i_btn2),
        .i_strobe (i_strobe),
        .i_read   (i_read2),
        .o_data   (o_data2)
    );

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// ---------------------------------------------------------------------------
// tb_nes_joypad_serializer
//
// Drives two serializer instances from the same stimulus. dut has SOCD
// cleaning on and dutRaw has it off. The reference model does not track a
// shift register. For each port it keeps the latched button byte and the
// number of reads since the latch. The expected bit is byte[count], or 1
// once count reaches 8.
// ---------------------------------------------------------------------------
module tb_nes_joypad_serializer;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_btn1 = 8'h00;
    logic [7:0] i_btn2 = 8'h00;
    logic       i_strobe = 1'b0;
    logic       i_read1 = 1'b0;
    logic       i_read2 = 1'b0;
    logic       o_data1, o_data2;
    logic       rawData1, rawData2;

    int checks = 0;
    int errors = 0;

    // Model state for each port: latched bytes for both instances and a
    // shared read count, saturated at 8.
    logic [7:0] latSocd[2] = '{8'h00, 8'h00};
    logic [7:0] latRaw[2]  = '{8'h00, 8'h00};
    int         readCnt[2] = '{0, 0};

    nes_joypad_serializer #(.C_SOCD(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_btn1(i_btn1), .i_btn2(i_btn2),
        .i_strobe(i_strobe), .i_read1(i_read1), .i_read2(i_read2),
        .o_data1(o_data1), .o_data2(o_data2)
    );

    nes_joypad_serializer #(.C_SOCD(1'b0)) dutRaw (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_btn1(i_btn1), .i_btn2(i_btn2),
        .i_strobe(i_strobe), .i_read1(i_read1), .i_read2(i_read2),
        .o_data1(rawData1), .o_data2(rawData2)
    );

    // Free-running core clock, 10 time units per period
    always #5 i_clk = ~i_clk;

    // An up+down pair or a left+right pair that is fully pressed reads as
    // neither direction pressed
    function automatic logic [7:0] socdModel(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b[4] && b[5]) r = r & 8'b1100_1111;
        if (b[6] && b[7]) r = r & 8'b0011_1111;
        return r;
    endfunction

    function automatic logic expectedBit(input logic [7:0] lat, input int cnt);
        if (cnt >= 8) return 1'b1;
        return lat[cnt];
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge so they are stable at the next rising edge
    task automatic applyStimulus(input logic [7:0] b1, input logic [7:0] b2,
                                 input logic s, input logic r1, input logic r2);
        @(negedge i_clk);
        i_btn1   = b1;
        i_btn2   = b2;
        i_strobe = s;
        i_read1  = r1;
        i_read2  = r2;
    endtask

    // Reference model. It advances on the same edges as the DUT, and reset
    // clears it immediately.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < 2; p++) begin
                latSocd[p] = 8'h00;
                latRaw[p]  = 8'h00;
                readCnt[p] = 0;
            end
        end else if (i_strobe) begin
            latSocd[0] = socdModel(i_btn1);
            latSocd[1] = socdModel(i_btn2);
            latRaw[0]  = i_btn1;
            latRaw[1]  = i_btn2;
            readCnt[0] = 0;
            readCnt[1] = 0;
        end else begin
            if (i_read1 && readCnt[0] < 8) readCnt[0] = readCnt[0] + 1;
            if (i_read2 && readCnt[1] < 8) readCnt[1] = readCnt[1] + 1;
        end
    end

    // Continuous comparison shortly after every rising edge
    always @(posedge i_clk) begin
        #1;
        checkOutput("stream socd data1", o_data1,  expectedBit(latSocd[0], readCnt[0]));
        checkOutput("stream socd data2", o_data2,  expectedBit(latSocd[1], readCnt[1]));
        checkOutput("stream raw data1",  rawData1, expectedBit(latRaw[0],  readCnt[0]));
        checkOutput("stream raw data2",  rawData2, expectedBit(latRaw[1],  readCnt[1]));
    end

    initial begin
        logic expSeq[10];
        expSeq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state while the inputs try to load all-ones
        i_btn1   = 8'hFF;
        i_strobe = 1'b1;
        #1;
        checkOutput("reset data1", o_data1, 1'b0);
        checkOutput("reset data2", o_data2, 1'b0);
        repeat (2) begin
            @(negedge i_clk);
            checkOutput("reset held data1", o_data1, 1'b0);
            checkOutput("reset held data2", o_data2, 1'b0);
        end
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b1;

        // Basic serialization of right, select and A
        applyStimulus(8'h85, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h85, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h85, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h85, 8'h00, 1'b0, 1'b1, 1'b0);
            checkOutput("basic sequence", o_data1, expSeq[i]);
        end

        // Strobe beats reads, and reload follows the buttons continuously
        applyStimulus(8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h00, 8'h02, 1'b1, 1'b0, 1'b1);
            checkOutput("strobe priority", o_data2, 1'b0);
        end
        applyStimulus(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        checkOutput("strobe reload", o_data2, 1'b1);

        // Opposite-direction cleaning on versus off
        applyStimulus(8'hF0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hF0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'hF0, 8'h00, 1'b0, 1'b1, 1'b0);
            checkOutput("socd cleaned", o_data1, 1'b0);
            checkOutput("socd raw", rawData1, (i >= 4) ? 1'b1 : 1'b0);
        end

        // Only port 2 is read, so port 1 keeps showing A
        applyStimulus(8'h01, 8'h80, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h01, 8'h80, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
            checkOutput("independent data2", o_data2, (i == 7) ? 1'b1 : 1'b0);
            checkOutput("independent data1", o_data1, 1'b1);
        end
        applyStimulus(8'h01, 8'h80, 1'b0, 1'b0, 1'b0);
        checkOutput("independent saturate", o_data2, 1'b1);

        // Simultaneous reads, then a reset partway through the sequence
        applyStimulus(8'h85, 8'h08, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h85, 8'h08, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(8'h85, 8'h08, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h85, 8'h08, 1'b0, 1'b0, 1'b0);
        checkOutput("simul data1 start", o_data1, 1'b0);
        checkOutput("simul data2 start", o_data2, 1'b1);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("midreset data1", o_data1, 1'b0);
        checkOutput("midreset data2", o_data2, 1'b0);
        checkOutput("midreset raw data2", rawData2, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus(8'h85, 8'h08, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h85, 8'h08, 1'b0, 1'b0, 1'b0);
        checkOutput("restart data1 A", o_data1, 1'b1);
        checkOutput("restart data2 A", o_data2, 1'b0);
        applyStimulus(8'h85, 8'h08, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h85, 8'h08, 1'b0, 1'b0, 1'b0);
        checkOutput("restart data1 B", o_data1, 1'b0);
        checkOutput("restart data2 B", o_data2, 1'b0);

        // Random traffic. The model stream checks every cycle.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(8'($urandom), 8'($urandom),
                          ($urandom_range(0, 7) == 0),
                          1'($urandom), 1'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #2 i_rst_n = 1'b0;
                @(negedge i_clk);
                i_rst_n = 1'b1;
            end
        end

        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
